// File: rtl/spi_ctrl_pkg.sv
// Shared widths and FSM state type for the SPI mode-0 master controller.
package spi_ctrl_pkg;

    localparam int unsigned LenW  = 4;
    localparam int unsigned DivW  = 8;
    localparam int unsigned DataW = 16;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StLow,
        StHigh,
        StHold,
        StResp
    } spi_state_e;

endpackage

// File: rtl/spi_ctrl_phase_timer.sv
// Phase timer: loads D-1 on every state change and flags the last cycle of the phase.
module spi_ctrl_phase_timer
    import spi_ctrl_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic            i_load,
    input  logic [DivW-1:0] i_div,
    output logic            o_phase_done
);

    logic [DivW-1:0] r_cnt;

    // Count down from the loaded divider value; holds at zero until the next load.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_div;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - DivW'(1);
        end
    end

    assign o_phase_done = (r_cnt == '0);

endmodule

// File: rtl/spi_ctrl.sv
// SPI mode-0 master: one request in, one response out, programmable length and SCK divider.
// Optional build macro SPI_CTRL_LSB_FIRST_EN switches the shift order to LSB-first.
module spi_ctrl
    import spi_ctrl_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [DataW-1:0] req_data,
    input  logic [LenW-1:0]  req_len,
    input  logic [DivW-1:0]  req_div,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [DataW-1:0] rsp_data,
    output logic             busy,
    output logic             sck,
    output logic             ss,
    output logic             mosi,
    input  logic             miso
);

    spi_state_e       r_state;
    logic [DataW-1:0] r_tx;
    logic [DataW-1:0] r_rx;
    logic [LenW-1:0]  r_len;
    logic [DivW-1:0]  r_div;
    logic [LenW-1:0]  r_bit_cnt;
    logic             r_sck;
    logic             r_ss;
    logic             r_mosi;
    logic             r_rsp_valid;
    logic [DataW-1:0] r_rsp_data;

    logic             w_accept;
    logic             w_timed;
    logic             w_phase_done;
    logic             w_load;
    logic [DivW-1:0]  w_load_div;
    logic             w_first_bit;
    logic             w_next_bit;
    logic [DataW-1:0] w_rx_next;

    assign w_accept   = (r_state == StIdle) && req_valid;
    assign w_timed    = (r_state == StSetup) || (r_state == StLow) ||
                        (r_state == StHigh) || (r_state == StHold);
    assign w_load     = w_accept || (w_timed && w_phase_done);
    // The divider is not latched yet on the accept cycle, so feed it straight through.
    assign w_load_div = (r_state == StIdle) ? req_div : r_div;

`ifdef SPI_CTRL_LSB_FIRST_EN
    assign w_first_bit = req_data[0];
    assign w_next_bit  = r_tx[r_bit_cnt + LenW'(1)];

    // Sampled bit k lands at rsp_data[k].
    always_comb begin
        w_rx_next            = r_rx;
        w_rx_next[r_bit_cnt] = miso;
    end
`else
    assign w_first_bit = req_data[req_len];
    assign w_next_bit  = r_tx[r_len - r_bit_cnt - LenW'(1)];
    // Shift in from the bottom so the first sample ends up at rsp_data[req_len].
    assign w_rx_next   = {r_rx[DataW-2:0], miso};
`endif

    spi_ctrl_phase_timer u_phase_timer (
        .clock        (clock),
        .reset        (reset),
        .i_load       (w_load),
        .i_div        (w_load_div),
        .o_phase_done (w_phase_done)
    );

    // Transfer FSM; all bus and response outputs are registered alongside the state.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= StIdle;
            r_tx        <= '0;
            r_rx        <= '0;
            r_len       <= '0;
            r_div       <= '0;
            r_bit_cnt   <= '0;
            r_sck       <= 1'b0;
            r_ss        <= 1'b1;
            r_mosi      <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (req_valid) begin
                        r_tx      <= req_data;
                        r_rx      <= '0;
                        r_len     <= req_len;
                        r_div     <= req_div;
                        r_bit_cnt <= '0;
                        r_ss      <= 1'b0;
                        r_sck     <= 1'b0;
                        r_mosi    <= w_first_bit;
                        r_state   <= StSetup;
                    end
                end
                StSetup, StLow: begin
                    if (w_phase_done) begin
                        r_sck   <= 1'b1;
                        r_rx    <= w_rx_next;
                        r_state <= StHigh;
                    end
                end
                StHigh: begin
                    if (w_phase_done) begin
                        r_sck <= 1'b0;
                        if (r_bit_cnt == r_len) begin
                            r_state <= StHold;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + LenW'(1);
                            r_mosi    <= w_next_bit;
                            r_state   <= StLow;
                        end
                    end
                end
                StHold: begin
                    if (w_phase_done) begin
                        r_ss        <= 1'b1;
                        r_mosi      <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= r_rx;
                        r_state     <= StResp;
                    end
                end
                StResp: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= StIdle;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign req_ready = (r_state == StIdle);
    assign busy      = (r_state != StIdle);
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign sck       = r_sck;
    assign ss        = r_ss;
    assign mosi      = r_mosi;

endmodule

// File: tb/tb_spi_ctrl.sv
// Directed + randomized bench for spi_ctrl against a bit-order/timing model.
module tb_spi_ctrl;

    localparam int Budget = 10000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [15:0] req_data = '0;
    logic [3:0]  req_len = '0;
    logic [7:0]  req_div = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_data;
    logic        busy;
    logic        sck;
    logic        ss;
    logic        mosi;
    logic        miso;
    logic        loop_en = 1'b0;
    logic        miso_drv = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    assign miso = loop_en ? mosi : miso_drv;

    always #5 clock = ~clock;

    spi_ctrl dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_len   (req_len),
        .req_div   (req_div),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .sck       (sck),
        .ss        (ss),
        .mosi      (mosi),
        .miso      (miso)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wire position of the k-th transmitted/sampled bit.
    function automatic int bit_pos(input int k, input int len);
`ifdef SPI_CTRL_LSB_FIRST_EN
        return k;
`else
        return len - k;
`endif
    endfunction

    // mode: 0 loopback, 1 miso tied high, 2 random miso pattern.
    task automatic xfer(input logic [15:0] data, input int len, input int div, input int mode,
                        input int hold, input bit poke);
        int n, d, cyc, got, pulses, ss_low, run, bad_phase, bad_mosi, bad_hold, pos;
        logic prev_sck, prev_mosi;
        logic [15:0] pat, exp_rsp, exp_mosi;
        logic mbit;
        n = len + 1;
        d = div + 1;
        pat = 16'($urandom());
        exp_rsp = '0;
        exp_mosi = '0;
        for (int k = 0; k < n; k++) begin
            pos = bit_pos(k, len);
            exp_mosi[k] = data[pos];
            mbit = (mode == 0) ? data[pos] : (mode == 1) ? 1'b1 : pat[k];
            exp_rsp[pos] = mbit;
        end

        @(negedge clock);
        check("idle_ready", {31'd0, req_ready}, 32'd1);
        req_data  = data;
        req_len   = 4'(len);
        req_div   = 8'(div);
        req_valid = 1'b1;
        loop_en   = (mode == 0);
        miso_drv  = (mode == 1) ? 1'b1 : pat[0];
        @(negedge clock);
        req_valid = 1'b0;

        cyc = 1; got = -1; pulses = 0; ss_low = 0; run = 0;
        bad_phase = 0; bad_mosi = 0; prev_sck = 1'b0; prev_mosi = 1'b1;
        while (got < 0 && cyc < Budget) begin
            if (rsp_valid === 1'b1) begin
                got = cyc;
            end else begin
                if (ss === 1'b0) ss_low++;
                if (sck !== prev_sck) begin
                    if (run != d) bad_phase++;
                    run = 0;
                end
                run++;
                if (sck === 1'b1 && prev_sck === 1'b0) begin
                    if (pulses < 16 && prev_mosi !== exp_mosi[pulses]) bad_mosi++;
                    pulses++;
                end
                prev_sck  = sck;
                prev_mosi = mosi;
                if (mode == 2 && pulses < 16) miso_drv = pat[pulses];
                // Junk on the request bus must be ignored while busy.
                req_data = 16'($urandom());
                req_len  = 4'($urandom());
                req_div  = 8'($urandom());
                @(negedge clock);
                cyc++;
            end
        end
        if (run != d) bad_phase++;

        check("rsp_cycle", 32'(got), 32'((2 * n + 1) * d + 1));
        if (got < 0) begin
            reset = 1'b1;
            @(negedge clock);
            reset = 1'b0;
            return;
        end
        check("rsp_data", {16'd0, rsp_data}, {16'd0, exp_rsp});
        check("sck_pulses", 32'(pulses), 32'(n));
        check("mosi_bits", 32'(bad_mosi), 32'd0);
        check("phase_len", 32'(bad_phase), 32'd0);
        check("ss_low_cycles", 32'(ss_low), 32'((2 * n + 1) * d));
        check("resp_bus", {29'd0, sck, ss, mosi}, 32'b011);
        check("resp_not_ready", {31'd0, req_ready}, 32'd0);

        bad_hold = 0;
        for (int i = 0; i < hold; i++) begin
            req_valid = poke && (i == 3);
            @(negedge clock);
            if (rsp_valid !== 1'b1 || rsp_data !== exp_rsp || req_ready !== 1'b0 ||
                busy !== 1'b1) bad_hold++;
        end
        req_valid = 1'b0;
        check("resp_hold_stable", 32'(bad_hold), 32'd0);

        rsp_ready = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
        check("after_resp", {26'd0, rsp_valid, busy, req_ready, sck, ss, mosi}, 32'b001011);
        if (poke) begin
            repeat (3) @(negedge clock);
            check("no_queued_req", {30'd0, busy, rsp_valid}, 32'd0);
        end
    endtask

    task automatic reset_mid();
        int pulses, cyc, bad;
        logic prev;
        @(negedge clock);
        check("rst_idle_ready", {31'd0, req_ready}, 32'd1);
        req_data = 16'hBEEF; req_len = 4'd15; req_div = 8'd2; req_valid = 1'b1;
        loop_en = 1'b1;
        @(negedge clock);
        req_valid = 1'b0;
        pulses = 0; cyc = 0; prev = 1'b0;
        while (pulses < 5 && cyc < 2000) begin
            if (sck === 1'b1 && prev === 1'b0) pulses++;
            prev = sck;
            if (pulses < 5) begin
                @(negedge clock);
                cyc++;
            end
        end
        check("rst_in_5th_high", {30'(pulses), sck, busy}, {30'd5, 2'b11});
        reset = 1'b1;
        @(negedge clock);
        check("rst_abort", {26'd0, ss, sck, busy, req_ready, rsp_valid, mosi}, 32'b100101);
        check("rst_rsp_data", {16'd0, rsp_data}, 32'd0);
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 120; i++) begin
            @(negedge clock);
            if (rsp_valid !== 1'b0 || sck !== 1'b0 || busy !== 1'b0) bad++;
        end
        check("rst_no_response", 32'(bad), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check("reset_outputs", {26'd0, ss, sck, busy, req_ready, rsp_valid, mosi}, 32'b100101);
        check("reset_rsp_data", {16'd0, rsp_data}, 32'd0);
        reset = 1'b0;
        @(negedge clock);
        check("idle_outputs", {26'd0, ss, sck, busy, req_ready, rsp_valid, mosi}, 32'b100101);

        xfer(16'hA5C3, 15, 0, 0, 0, 1'b0);
        xfer(16'h0005, 2, 3, 0, 2, 1'b0);
        xfer(16'h1234, 7, 1, 1, 0, 1'b0);
        xfer(16'h00C9, 7, 2, 2, 10, 1'b1);
        reset_mid();
        xfer(16'($urandom()), 0, 255, 2, 1, 1'b0);
        xfer(16'hFFFF, 15, 0, 2, 0, 1'b0);
`ifdef SPI_CTRL_LSB_FIRST_EN
        xfer(16'h0001, 3, 0, 0, 0, 1'b0);
`endif
        for (int t = 0; t < 12; t++) begin
            xfer(16'($urandom()), int'($urandom_range(0, 15)), int'($urandom_range(0, 5)),
                 int'($urandom_range(0, 2)), int'($urandom_range(0, 6)),
                 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
